dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-ported, word-organised data memory. It shares the memory between the pipeline MEM stage (port 0) and the SAD window loader (port 1) using round-robin arbitration. Sub-word stores become read-modify-write sequences, and sub-word loads are lane-extracted with sign or zero extension, so the memory only ever sees aligned whole-word accesses.

## Interface
Parameters:
- `MEM_WORDS`, default 1024: memory depth in words. Legal byte addresses are `0 .. 4*MEM_WORDS-1`.

Ports:
- `clk` (in, 1): single clock. All state updates on posedge.
- `Reset` (in, 1): asynchronous, active-high.
- `req[1:0]` (in, 2): per-port request. Held high until that port's `ack`.
- `we[1:0]` (in, 2): per-port store (1) or load (0).
- `size0`, `size1` (in, 2 each): access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `sgn[1:0]` (in, 2): per-port sign-extend for sub-word loads.
- `addr0`, `addr1` (in, 32 each): byte addresses.
- `wdata0`, `wdata1` (in, 32 each): store data, right-justified.
- `ack[1:0]` (out, 2): one-cycle completion pulse per port.
- `err` (out, 1): valid with `ack`. Set for misaligned, out-of-range, or illegal-size access.
- `rdata` (out, 32): load result, valid with `ack`.
- `mem_Address` (out, 32): word-aligned address, `{addr[31:2],2'b00}`.
- `mem_WriteData` (out, 32): word written to memory.
- `mem_MemWrite` (out, 1): memory write enable.
- `mem_MemRead` (out, 1): memory read enable.
- `mem_ReadData` (in, 32): combinational read data from memory.

## Operation
States: IDLE, RD, RMW_RD, WR, DONE.

- **IDLE**
  - If any `req` is high, pick a winner round-robin. The port not granted last wins a tie. `last` resets to 1, so port 0 wins the first tie.
  - Latch the winner's `we`, `size`, `sgn`, `addr` and `wdata`, and update `last`.
  - Next state is decided from the latched request:
    - Error condition → DONE with `err=1`. No memory access, no write.
    - Load of any size → RD.
    - Word store → WR.
    - Byte or half store → RMW_RD.
- **Error conditions** (any one sets `err`):
  - half access with `addr[0]=1`;
  - word access with `addr[1:0]≠0`;
  - size 11;
  - `addr ≥ 4*MEM_WORDS`.
- **RD**
  - Drive `mem_MemRead=1`.
  - Capture `mem_ReadData` at the posedge, extracted and extended as below → DONE.
- **Load lane extraction**
  - Byte lane = `addr[1:0]`; lane 0 is bits 7:0.
  - Half lane = `addr[1]`; lane 0 is bits 15:0.
  - Extension is sign (`sgn=1`) or zero (`sgn=0`). Word loads pass through unchanged.
- **RMW_RD**
  - Drive `mem_MemRead=1` and capture the full word into `merge_buf` → WR.
- **WR**
  - Drive `mem_MemWrite=1` for the whole cycle; memory commits on negedge.
  - Write data:
    - word store: `wdata`;
    - byte/half store: `merge_buf` with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - → DONE.
- **DONE**
  - `ack[winner]=1` for exactly this cycle, with `rdata` valid (0 for stores) and `err` valid.
  - `req` is ignored this cycle → IDLE.
- **Memory signals**
  - `mem_MemRead` and `mem_MemWrite` are never high together.
  - In IDLE and DONE, all `mem_*` outputs are 0.

## Timing
- **Reset values:** `ack=0`, `err=0`, `rdata=0`, all `mem_*=0`, state IDLE, `last=1`, `merge_buf=0`.
- **Latency** (request sampled at edge 0):
  - loads and word stores: `ack` in cycle 2;
  - byte/half stores: `ack` in cycle 3;
  - error cases: `ack` in cycle 1.
- **Back-to-back:** minimum 3 cycles between grants, or 4 for RMW. A `req` still high after its `ack` is treated as a new request in IDLE.
- **Simultaneous requests:** both `req` high in IDLE → the non-`last` port wins. The loser keeps `req` asserted and is granted at the next IDLE, so there is no starvation.
- **Request changes:** changes to non-granted port inputs during a transaction are ignored. The granted port's inputs are ignored after latching.
- **Reset mid-operation:** all outputs clear immediately. A reset asserted during WR before negedge suppresses the write. No `ack` is issued for the aborted transaction.

## Structure
- **Shared package `dmem_pkg`:**
  - size encodings `SZ_BYTE=2'b00`, `SZ_HALF=2'b01`, `SZ_WORD=2'b10`;
  - state encoding.
- **Sub-module `dmem_lane_unit`:** combinational. Inputs are word, `addr[1:0]`, size, `sgn` and `wdata`. Outputs are the load-extracted value and the store-merged word. Instantiated once.

## Test plan
- **Load extraction.** Memory word 4 = 0x80FF_7F01.
  - byte load at `addr0=0x12`, `sgn=1` → `rdata=0xFFFF_FFFF`;
  - byte load at 0x13, `sgn=0` → 0x0000_0080;
  - half load at 0x10, `sgn=1` → 0x0000_7F01;
  - `ack[0]` in cycle 2 for each.
- **Byte store.** Word 4 = 0x1122_3344; byte store of 0xAB to address 0x11 → word 4 = 0x1122_AB44. Sequence RMW_RD, WR, `ack` in cycle 3. No other word is written.
- **Contention.** Both ports request word loads in the same cycle from reset → port 0 acked first, port 1 acked 3 cycles later. Repeat with both held high → grants alternate 0, 1, 0, 1.
- **Errors.**
  - half load at 0x21 → `ack` in cycle 1, `err=1`, no `mem_MemRead`;
  - word store at 0x1000 (`MEM_WORDS=1024`) → `err=1`, no `mem_MemWrite`;
  - `size=11` → `err=1`.
- **Reset during RMW.** Assert `Reset` in the RMW_RD cycle of a half store → `mem_MemWrite` never rises, word unchanged, outputs 0. After deassert, the next request completes normally.
- **Protocol check.** A checker runs across all scenarios and asserts:
  - `mem_MemRead` and `mem_MemWrite` are never both high;
  - `ack` is never two cycles consecutive for one port;
  - `ack` is never high on both ports in the same cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, sequencer states, access checks.
// Pure declarations; no timing or flow control of its own.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_DONE
    } state_t;

    // limit is the first illegal byte address, widened so 4*MEM_WORDS never wraps
    function automatic logic access_err(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [32:0] limit);
        logic bad_align;
        bad_align = ((size == SZ_HALF) && addr[0]) ||
                    ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        return bad_align || (size == SZ_ILL) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
// Purely combinational, zero latency; no flow control.
module dmem_lane_unit (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sgn,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);
    import dmem_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_word[7:0];
        w_half  = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_load  = i_word;
        o_merge = i_word;
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        case (i_size)
            SZ_BYTE: begin
                o_load = {{24{i_sgn & w_byte[7]}}, w_byte};
                case (i_addr_lo)
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    2'd3:    o_merge[31:24] = i_wdata[7:0];
                    default: o_merge[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                o_load = {{16{i_sgn & w_half[15]}}, w_half};
                if (i_addr_lo[1]) o_merge[31:16] = i_wdata;
                else              o_merge[15:0]  = i_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for a single-ported word memory.
// Ack after 2 cycles (load/word store), 3 (sub-word store, RMW), 1 (error); requesters hold req until ack.
module dmem_arbiter #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [1:0]  sgn,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_Address,
    output logic [31:0] mem_WriteData,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_ReadData
);
    import dmem_pkg::*;

    localparam logic [32:0] LP_LIMIT = {31'(MEM_WORDS), 2'b00};

    state_t      r_state;
    logic        r_last;
    logic        r_win;
    logic [1:0]  r_size;
    logic        r_sgn;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge_buf;
    logic [1:0]  r_ack;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_win;
    logic        w_we;
    logic [1:0]  w_size;
    logic        w_sgn;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic [31:0] w_lane_word;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic        w_busy;

    // A lone requester wins outright; on a tie the port not granted last wins.
    always_comb begin
        w_win = ~r_last;
        if (req == 2'b01)      w_win = 1'b0;
        else if (req == 2'b10) w_win = 1'b1;
    end

    assign w_we    = w_win ? we[1]  : we[0];
    assign w_size  = w_win ? size1  : size0;
    assign w_sgn   = w_win ? sgn[1] : sgn[0];
    assign w_addr  = w_win ? addr1  : addr0;
    assign w_wdata = w_win ? wdata1 : wdata0;
    assign w_err   = access_err(w_size, w_addr, LP_LIMIT);

    // During WR the lane unit merges into the buffered word; otherwise it sees live read data.
    assign w_lane_word = (r_state == ST_WR) ? r_merge_buf : mem_ReadData;

    dmem_lane_unit u_lane (
        .i_word    (w_lane_word),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .i_sgn     (r_sgn),
        .i_wdata   (r_wdata[15:0]),
        .o_load    (w_load),
        .o_merge   (w_merge)
    );

    assign w_busy        = (r_state == ST_RD) || (r_state == ST_RMW_RD) || (r_state == ST_WR);
    assign mem_MemRead   = (r_state == ST_RD) || (r_state == ST_RMW_RD);
    assign mem_MemWrite  = (r_state == ST_WR);
    assign mem_Address   = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_WriteData = (r_state == ST_WR) ? ((r_size == SZ_WORD) ? r_wdata : w_merge) : 32'h0;

    assign ack   = r_ack;
    assign err   = r_err;
    assign rdata = r_rdata;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_win       <= 1'b0;
            r_size      <= SZ_BYTE;
            r_sgn       <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_merge_buf <= 32'h0;
            r_ack       <= 2'b00;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_win   <= w_win;
                        r_last  <= w_win;
                        r_size  <= w_size;
                        r_sgn   <= w_sgn;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_rdata <= 32'h0;
                        if (w_err) begin
                            r_err   <= 1'b1;
                            r_ack   <= w_win ? 2'b10 : 2'b01;
                            r_state <= ST_DONE;
                        end else if (!w_we) begin
                            r_state <= ST_RD;
                        end else if (w_size == SZ_WORD) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RMW_RD;
                        end
                    end
                end
                ST_RD: begin
                    r_rdata <= w_load;
                    r_ack   <= r_win ? 2'b10 : 2'b01;
                    r_state <= ST_DONE;
                end
                ST_RMW_RD: begin
                    r_merge_buf <= mem_ReadData;
                    r_state     <= ST_WR;
                end
                ST_WR: begin
                    r_ack   <= r_win ? 2'b10 : 2'b01;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack   <= 2'b00;
                    r_err   <= 1'b0;
                    r_rdata <= 32'h0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural word memory, vector table, corner sequences and a protocol watcher.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        Reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  size0, size1;
    logic [1:0]  sgn;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_Address, mem_WriteData, mem_ReadData;
    logic        mem_MemWrite, mem_MemRead;

    logic [31:0] mem [1024];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;

    typedef struct {
        int          port;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        int          cyc;
        logic        err;
        logic [31:0] rd;
        logic        mrd;
        logic        mwr;
    } vec_t;

    localparam int NV = 15;
    vec_t tv [NV];

    always #5 clk = ~clk;

    assign mem_ReadData = (mem_Address < 32'h1000) ? mem[mem_Address[11:2]] : 32'hDEAD_0000;

    dmem_arbiter #(.MEM_WORDS(1024)) dut (
        .clk           (clk),
        .Reset         (Reset),
        .req           (req),
        .we            (we),
        .size0         (size0),
        .size1         (size1),
        .sgn           (sgn),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .ack           (ack),
        .err           (err),
        .rdata         (rdata),
        .mem_Address   (mem_Address),
        .mem_WriteData (mem_WriteData),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_ReadData  (mem_ReadData)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ack"},  {30'h0, ack}, 32'h0);
        chk({nm, "_err"},  {31'h0, err}, 32'h0);
        chk({nm, "_rdata"}, rdata, 32'h0);
        chk({nm, "_maddr"}, mem_Address, 32'h0);
        chk({nm, "_mwdat"}, mem_WriteData, 32'h0);
        chk({nm, "_mrd"},  {31'h0, mem_MemRead}, 32'h0);
        chk({nm, "_mwr"},  {31'h0, mem_MemWrite}, 32'h0);
    endtask

    // Called just after a negedge with the DUT idle; returns one negedge after ack so the DUT is back in IDLE.
    task automatic run_req(input int port, input logic w, input logic [1:0] sz, input logic s,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int cyc, output logic e, output logic [31:0] rd,
                           output logic srd, output logic swr);
        bit done;
        if (port == 0) begin
            we[0] = w; size0 = sz; sgn[0] = s; addr0 = a; wdata0 = wd; req[0] = 1'b1;
        end else begin
            we[1] = w; size1 = sz; sgn[1] = s; addr1 = a; wdata1 = wd; req[1] = 1'b1;
        end
        srd = 1'b0; swr = 1'b0; e = 1'b0; rd = 32'h0; cyc = -1; done = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 10 && !done; c++) begin
            @(negedge clk);
            srd = srd | mem_MemRead;
            swr = swr | mem_MemWrite;
            if (ack[port]) begin
                cyc = c; e = err; rd = rdata; done = 1'b1;
            end
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        int          cyc, a0, a1, k;
        logic        e, srd, swr, seen_ack, seen_wr;
        logic [31:0] rd, d0, d1;
        logic [1:0]  prev_ack;
        int          order [4];
        int          when  [4];

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        Reset = 1'b1; req = 2'b00; we = 2'b00; size0 = SZ_WORD; size1 = SZ_WORD;
        sgn = 2'b00; addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        prev_ack = 2'b00;

        fork
            forever begin
                @(negedge clk);
                if (mem_MemWrite && mem_Address < 32'h1000) begin
                    mem[mem_Address[11:2]] = mem_WriteData;
                    n_writes++;
                end
            end
            forever begin
                @(negedge clk);
                chk("proto_rd_wr_excl", {31'h0, mem_MemRead & mem_MemWrite}, 32'h0);
                chk("proto_ack_both",   {31'h0, &ack}, 32'h0);
                chk("proto_ack_consec", {30'h0, ack & prev_ack}, 32'h0);
                if (mem_MemRead || mem_MemWrite)
                    chk("proto_addr_align", {30'h0, mem_Address[1:0]}, 32'h0);
                prev_ack = Reset ? 2'b00 : ack;
            end
        join_none

        #1;
        chk_idle_outputs("reset");
        repeat (2) @(negedge clk);
        Reset = 1'b0;

        mem[4]    = 32'h80FF_7F01;
        mem[1023] = 32'hA500_0000;

        tv[0]  = '{0, 1'b0, SZ_BYTE, 1'b1, 32'h12,        32'h0,        2, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tv[1]  = '{0, 1'b0, SZ_BYTE, 1'b0, 32'h13,        32'h0,        2, 1'b0, 32'h0000_0080, 1'b1, 1'b0};
        tv[2]  = '{0, 1'b0, SZ_HALF, 1'b1, 32'h10,        32'h0,        2, 1'b0, 32'h0000_7F01, 1'b1, 1'b0};
        tv[3]  = '{1, 1'b0, SZ_HALF, 1'b1, 32'h12,        32'h0,        2, 1'b0, 32'hFFFF_80FF, 1'b1, 1'b0};
        tv[4]  = '{1, 1'b0, SZ_HALF, 1'b0, 32'h12,        32'h0,        2, 1'b0, 32'h0000_80FF, 1'b1, 1'b0};
        tv[5]  = '{0, 1'b0, SZ_WORD, 1'b1, 32'h10,        32'h0,        2, 1'b0, 32'h80FF_7F01, 1'b1, 1'b0};
        tv[6]  = '{1, 1'b0, SZ_BYTE, 1'b1, 32'h11,        32'h0,        2, 1'b0, 32'h0000_007F, 1'b1, 1'b0};
        tv[7]  = '{0, 1'b0, SZ_HALF, 1'b0, 32'h21,        32'h0,        1, 1'b1, 32'h0,         1'b0, 1'b0};
        tv[8]  = '{1, 1'b1, SZ_WORD, 1'b0, 32'h1000,      32'h1234_5678, 1, 1'b1, 32'h0,        1'b0, 1'b0};
        tv[9]  = '{0, 1'b0, SZ_ILL,  1'b0, 32'h10,        32'h0,        1, 1'b1, 32'h0,         1'b0, 1'b0};
        tv[10] = '{0, 1'b0, SZ_WORD, 1'b0, 32'h12,        32'h0,        1, 1'b1, 32'h0,         1'b0, 1'b0};
        tv[11] = '{1, 1'b1, SZ_WORD, 1'b0, 32'h20,        32'hDEAD_BEEF, 2, 1'b0, 32'h0,        1'b0, 1'b1};
        tv[12] = '{0, 1'b0, SZ_WORD, 1'b0, 32'h20,        32'h0,        2, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tv[13] = '{0, 1'b0, SZ_BYTE, 1'b1, 32'hFFF,       32'h0,        2, 1'b0, 32'hFFFF_FFA5, 1'b1, 1'b0};
        tv[14] = '{1, 1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0,        1, 1'b1, 32'h0,         1'b0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            run_req(tv[i].port, tv[i].w, tv[i].sz, tv[i].sg, tv[i].addr, tv[i].wd, cyc, e, rd, srd, swr);
            chk($sformatf("v%0d_cycle", i), cyc, tv[i].cyc);
            chk($sformatf("v%0d_err", i),   {31'h0, e}, {31'h0, tv[i].err});
            chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
            chk($sformatf("v%0d_memrd", i), {31'h0, srd}, {31'h0, tv[i].mrd});
            chk($sformatf("v%0d_memwr", i), {31'h0, swr}, {31'h0, tv[i].mwr});
        end

        // Sub-word stores go through read-modify-write and touch only the addressed word.
        mem[4] = 32'h1122_3344;
        n_writes = 0;
        run_req(0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFF_FFAB, cyc, e, rd, srd, swr);
        chk("bst_cycle", cyc, 3);
        chk("bst_err", {31'h0, e}, 32'h0);
        chk("bst_rmw_rd", {31'h0, srd}, 32'h1);
        chk("bst_word", mem[4], 32'h1122_AB44);
        chk("bst_nwrites", n_writes, 1);
        run_req(1, 1'b1, SZ_HALF, 1'b1, 32'h12, 32'hFFFF_5566, cyc, e, rd, srd, swr);
        chk("hst_cycle", cyc, 3);
        chk("hst_word", mem[4], 32'h5566_AB44);
        chk("hst_rdata", rd, 32'h0);

        // Contention straight out of reset: port 0 first, port 1 three cycles later.
        mem[4] = 32'h0404_0404;
        mem[8] = 32'h0808_0808;
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        we = 2'b00; size0 = SZ_WORD; size1 = SZ_WORD; addr0 = 32'h10; addr1 = 32'h20;
        req = 2'b11;
        a0 = -1; a1 = -1; d0 = 32'h0; d1 = 32'h0;
        @(posedge clk);
        for (int c = 1; c <= 20 && (a0 < 0 || a1 < 0); c++) begin
            @(negedge clk);
            if (ack[0] && a0 < 0) begin a0 = c; d0 = rdata; req[0] = 1'b0; end
            if (ack[1] && a1 < 0) begin a1 = c; d1 = rdata; req[1] = 1'b0; end
        end
        req = 2'b00;
        @(negedge clk);
        chk("cont_ack0_cycle", a0, 2);
        chk("cont_ack1_cycle", a1, 5);
        chk("cont_rdata0", d0, 32'h0404_0404);
        chk("cont_rdata1", d1, 32'h0808_0808);

        // Both held high: grants alternate, each three cycles apart.
        req = 2'b11;
        k = 0;
        for (int i = 0; i < 4; i++) begin order[i] = -1; when[i] = -1; end
        @(posedge clk);
        for (int c = 1; c <= 40 && k < 4; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                order[k] = ack[1] ? 1 : 0;
                when[k]  = c;
                k++;
            end
        end
        req = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("alt%0d_port", i),  order[i], i % 2);
            chk($sformatf("alt%0d_cycle", i), when[i],  2 + 3 * i);
        end

        // Reset in the RMW_RD cycle of a half store aborts it with no write and no ack.
        mem[4] = 32'h1122_3344;
        n_writes = 0;
        we[0] = 1'b1; size0 = SZ_HALF; sgn[0] = 1'b0; addr0 = 32'h10; wdata0 = 32'h0000_9999;
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rmw_rd_phase", {31'h0, mem_MemRead}, 32'h1);
        Reset = 1'b1;
        req = 2'b00;
        #1;
        chk_idle_outputs("rst_mid");
        seen_ack = 1'b0; seen_wr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) Reset = 1'b0;
            seen_ack = seen_ack | (|ack);
            seen_wr  = seen_wr | mem_MemWrite;
        end
        chk("rst_no_ack", {31'h0, seen_ack}, 32'h0);
        chk("rst_no_memwr", {31'h0, seen_wr}, 32'h0);
        chk("rst_nwrites", n_writes, 0);
        chk("rst_word_kept", mem[4], 32'h1122_3344);
        run_req(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, cyc, e, rd, srd, swr);
        chk("post_rst_cycle", cyc, 2);
        chk("post_rst_rdata", rd, 32'h1122_3344);
        chk("post_rst_err", {31'h0, e}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
